// File: rtl/new_test_pkg.sv
// Shared die type, face limits and seven-segment patterns for the dice roller.
package new_test_pkg;

  typedef logic [2:0] die_t;

  localparam die_t DIE_MIN = 3'd1;
  localparam die_t DIE_MAX = 3'd6;

  // Segment order is {A,B,C,D,E,F,G}, active-high.
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_ERR = 7'b0000001;

  // Out-of-range faces snap back to DIE_MIN so an upset self-heals.
  function automatic die_t die_next(input die_t d);
    if (d >= DIE_MAX || d < DIE_MIN) return DIE_MIN;
    return d + 3'd1;
  endfunction

endpackage

// File: rtl/seg7_die.sv
// Combinational die-face to seven-segment decode; illegal faces show segment G only.
module seg7_die
  import new_test_pkg::*;
(
  input  die_t       die,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    case (die)
      3'd1: seg = SEG_1;
      3'd2: seg = SEG_2;
      3'd3: seg = SEG_3;
      3'd4: seg = SEG_4;
      3'd5: seg = SEG_5;
      3'd6: seg = SEG_6;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/new_test.sv
// Two-dice roller with doubles buzzer. Define NEW_TEST_SW_SYNC_EN to put a
// two-flop synchronizer on SW instead of a single register.
module new_test
  import new_test_pkg::*;
#(
  parameter int unsigned BUZZ_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW,
  output logic A1, B1, C1, D1, E1, F1, G1,
  output logic A2, B2, C2, D2, E2, F2, G2,
  output logic Buzzer
);

  localparam int  NUM_DICE  = 2;
  localparam logic [7:0] BUZZ_INIT = 8'(BUZZ_CYCLES);

  logic                         sw_q;
  logic                         sw_q_d;
  logic                         phase;
  logic                         stop_evt;
  logic [7:0]                   buzz_cnt;
  die_t [NUM_DICE-1:0]          dice;
  logic [NUM_DICE-1:0][6:0]     segs;

`ifdef NEW_TEST_SW_SYNC_EN
  logic sw_meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      sw_meta <= SW;
      sw_q    <= sw_meta;
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sw_q <= 1'b0;
    else        sw_q <= SW;
  end
`endif

  // Stop is the first non-rolling edge after at least one rolling edge.
  assign stop_evt = !sw_q && sw_q_d;

  // die2 steps on every other rolling edge, tracked by phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dice   <= {DIE_MIN, DIE_MIN};
      phase  <= 1'b0;
      sw_q_d <= 1'b0;
    end else begin
      sw_q_d <= sw_q;
      if (sw_q) begin
        dice[0] <= die_next(dice[0]);
        if (phase) dice[1] <= die_next(dice[1]);
        phase <= !phase;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              buzz_cnt <= '0;
    else if (sw_q)                           buzz_cnt <= '0;
    else if (stop_evt && dice[0] == dice[1]) buzz_cnt <= BUZZ_INIT;
    else if (buzz_cnt != '0)                 buzz_cnt <= buzz_cnt - 8'd1;
  end

  assign Buzzer = (buzz_cnt != '0);

  for (genvar i = 0; i < NUM_DICE; i++) begin : g_seg
    seg7_die u_seg (
      .die (dice[i]),
      .seg (segs[i])
    );
  end

  assign {A1, B1, C1, D1, E1, F1, G1} = segs[0];
  assign {A2, B2, C2, D2, E2, F2, G2} = segs[1];

endmodule

// File: tb/tb_new_test.sv
// Scoreboard bench for new_test: a per-edge model pushes expected displays and
// buzzer state, popped and compared at the following falling edge.
module tb_new_test;

  localparam int BUZZ = 16;
`ifdef NEW_TEST_SW_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic SW = 1'b0;
  logic A1, B1, C1, D1, E1, F1, G1;
  logic A2, B2, C2, D2, E2, F2, G2;
  logic Buzzer;

  always #5 CLK = ~CLK;

  new_test #(.BUZZ_CYCLES(BUZZ)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW),
    .A1(A1), .B1(B1), .C1(C1), .D1(D1), .E1(E1), .F1(F1), .G1(G1),
    .A2(A2), .B2(B2), .C2(C2), .D2(D2), .E2(E2), .F2(F2), .G2(G2),
    .Buzzer(Buzzer)
  );

  typedef struct packed {
    logic [6:0] s1;
    logic [6:0] s2;
    logic       bz;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model state
  int         m_n;
  logic       m_swq, m_swq_d;
  logic [1:0] m_pipe;
  int         m_cnt;
  int         bz_hi;

  function automatic logic [6:0] seg_of(input int f);
    case (f)
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic int d1_of(input int n);
    return (n % 6) + 1;
  endfunction

  function automatic int d2_of(input int n);
    return ((n / 2) % 6) + 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg1();
    return {A1, B1, C1, D1, E1, F1, G1};
  endfunction

  function automatic logic [6:0] seg2();
    return {A2, B2, C2, D2, E2, F2, G2};
  endfunction

  task automatic model_reset();
    m_n = 0; m_swq = 1'b0; m_swq_d = 1'b0; m_pipe = 2'b00; m_cnt = 0;
  endtask

  // One clock: drive SW, advance the model at the edge, compare at the falling edge.
  task automatic step(input logic s);
    exp_t e, got;
    SW = s;
    @(posedge CLK);
    if (m_swq) begin
      m_n++;
      m_cnt = 0;
    end else if (m_swq_d && d1_of(m_n) == d2_of(m_n)) begin
      m_cnt = BUZZ;
    end else if (m_cnt != 0) begin
      m_cnt--;
    end
    m_swq_d = m_swq;
    m_pipe  = {m_pipe[0], s};
    m_swq   = (LAT == 2) ? m_pipe[1] : m_pipe[0];
    e.s1 = seg_of(d1_of(m_n));
    e.s2 = seg_of(d2_of(m_n));
    e.bz = (m_cnt != 0);
    exp_q.push_back(e);
    @(negedge CLK);
    got = exp_q.pop_front();
    chk("seg1", 16'(seg1()), 16'(got.s1));
    chk("seg2", 16'(seg2()), 16'(got.s2));
    chk("buzzer", 16'(Buzzer), 16'(got.bz));
    if (Buzzer) bz_hi++;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 RST_N = 1'b0;
    #1;
    chk({tag, "_seg1"}, 16'(seg1()), 16'(7'b0110000));
    chk({tag, "_seg2"}, 16'(seg2()), 16'(7'b0110000));
    chk({tag, "_buzz"}, 16'(Buzzer), 16'(1'b0));
    model_reset();
    SW = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic repeat_step(input logic s, input int k);
    for (int i = 0; i < k; i++) step(s);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_seg1", 16'(seg1()), 16'(7'b0110000));
    chk("rst_seg2", 16'(seg2()), 16'(7'b0110000));
    chk("rst_buzz", 16'(Buzzer), 16'(1'b0));
    RST_N = 1'b1;

    // Idle after reset
    bz_hi = 0;
    repeat_step(1'b0, 20);
    chk("idle_buzz_cycles", 16'(bz_hi), 16'd0);

    // 12 rolling edges land on doubles (1,1): full-length alarm
    repeat_step(1'b1, 12);
    bz_hi = 0;
    repeat_step(1'b0, 24);
    chk("dbl12_seg1", 16'(seg1()), 16'(7'b0110000));
    chk("dbl12_seg2", 16'(seg2()), 16'(7'b0110000));
    chk("dbl12_buzz_cycles", 16'(bz_hi), 16'(BUZZ));

    // 5 more rolling edges: 6 and 3, no alarm
    repeat_step(1'b1, 5);
    bz_hi = 0;
    repeat_step(1'b0, 6);
    chk("r5_seg1", 16'(seg1()), 16'(7'b1011111));
    chk("r5_seg2", 16'(seg2()), 16'(7'b1111001));
    chk("r5_buzz_cycles", 16'(bz_hi), 16'd0);

    // 7 more edges -> total 24 -> doubles; resume rolling on 4th alarm cycle
    repeat_step(1'b1, 7);
    bz_hi = 0;
    guard = 0;
    while (bz_hi < 4 && guard < 12) begin
      step(1'b0);
      guard++;
    end
    chk("alarm_reached", 16'(bz_hi), 16'd4);
    bz_hi = 0;
    repeat_step(1'b1, 6);
    chk("alarm_cleared_seg1", 16'(seg1()), 16'(seg_of(d1_of(m_n))));
    repeat_step(1'b0, 4);
    chk("alarm_cleared_buzz", 16'(Buzzer), 16'(1'b0));

    // Asynchronous reset mid-roll
    repeat_step(1'b1, 3);
    async_reset("rst_roll");
    repeat_step(1'b0, 3);

    // Asynchronous reset mid-alarm
    repeat_step(1'b1, 12);
    repeat_step(1'b0, 5);
    chk("pre_rst_alarm", 16'(Buzzer), 16'(1'b1));
    async_reset("rst_alarm");
    repeat_step(1'b0, 3);

    // Random switch runs
    for (int r = 0; r < 30; r++)
      repeat_step(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    repeat_step(1'b0, 20);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/new_test.md
NEW_TEST -- requirements
Module: new_test

Interface
REQ-001 The block SHALL expose parameter BUZZ_CYCLES, default 16: number of clock cycles Buzzer stays high after a matching stop; legal range 1..255.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: CLK  input  1  sole clock, rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 SW  input  1  roll switch: 1 = rolling, 0 = stopped.
REQ-005 A1,B1,C1,D1,E1,F1,G1  output  1 each  die-1 seven-segment drive, active-high.
REQ-006 A2,B2,C2,D2,E2,F2,G2  output  1 each  die-2 seven-segment drive, active-high.
REQ-007 Buzzer  output  1  high while a doubles alarm is active.

Function
REQ-008 The block SHALL hold two 3-bit die registers, die1 and die2, each always in 1..6.
REQ-009 The block SHALL treat SW_q as the effective switch: SW registered once, or the synchronizer output when enabled (REQ-021).
REQ-010 On each rising edge with SW_q=1, die1 SHALL advance by one, wrapping 6->1.
REQ-011 A phase bit P SHALL toggle on each rising edge with SW_q=1; die2 SHALL advance (wrapping 6->1) on those edges where P=1 before the edge, giving half rate.
REQ-012 With SW_q=0, die1, die2 and P SHALL hold.
REQ-013 After N consecutive rolling edges from reset: die1 = (N mod 6)+1; die2 = (floor(N/2) mod 6)+1.
REQ-014 A stop event SHALL be the first edge with SW_q=0 after one or more edges with SW_q=1.
REQ-015 On a stop event with die1==die2, Buzzer SHALL go high from that edge and stay high for exactly BUZZ_CYCLES cycles. With die1!=die2, Buzzer SHALL stay low.
REQ-016 SW_q returning to 1 while Buzzer is high SHALL clear Buzzer on the same edge.
REQ-017 The segment outputs SHALL be combinational decodes of die1 and die2. Pattern order is {A,B,C,D,E,F,G}: 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111. Any illegal value SHALL decode to 0000001.
REQ-018 Segment outputs SHALL update every cycle while rolling; no blanking.

Reset
REQ-019 While RST_N=0, the block SHALL asynchronously set: die1=1, die2=1, P=0, SW_q=0, buzzer counter=0, Buzzer=0. Both displays SHALL show 0110000.
REQ-020 Reset asserted mid-roll or mid-alarm SHALL abort immediately. After release, rolling SHALL resume only on SW_q=1.

Configuration
REQ-021 With macro NEW_TEST_SW_SYNC_EN defined, SW SHALL pass through a two-flop synchronizer before SW_q, adding 2 cycles of start/stop latency. Without it, SW SHALL be registered once (1 cycle latency).

Structure
REQ-022 Package new_test_pkg SHALL hold the die type (3-bit), the DIE_MIN/DIE_MAX constants (1/6) and the six 7-bit segment pattern constants.
REQ-023 Sub-module seg7_die SHALL implement the REQ-017 decode and SHALL be instantiated twice.
REQ-024 The counters, phase bit, stop detector and buzzer timer SHALL live in new_test.

Verification
REQ-025 Reset then no SW activity for 20 cycles -> both displays 0110000, Buzzer=0 throughout.
REQ-026 SW=1 for 12 effective rolling edges, then SW=0 -> die1=1, die2=1, both 0110000, Buzzer high for exactly 16 cycles.
REQ-027 SW=1 for 5 effective rolling edges, then SW=0 -> display1 1011111 (6), display2 1111001 (3), Buzzer stays 0.
REQ-028 Doubles stop (REQ-026), then SW=1 on the 4th alarm cycle -> Buzzer clears at the first SW_q=1 edge and dice resume advancing.
REQ-029 RST_N pulsed low mid-roll and mid-alarm -> all outputs at reset values without waiting for a clock edge.
REQ-030 Repeat REQ-026 with and without NEW_TEST_SW_SYNC_EN -> identical dice values, with roll start/stop shifted by 2 vs 1 cycles.
